// File: rtl/ws2812b_rx.sv
// WS2812B receiver: decodes the single-wire NRZ LED stream into 24-bit GRB
// pixels, with an optional chain mode that captures the first pixel of each
// frame and forwards the remainder of the stream on WS2812B_DOUT.
module ws2812b_rx #(
  parameter int unsigned MIN_HIGH_CYC   = 3,
  parameter int unsigned BIT_THRESH_CYC = 16,
  parameter int unsigned MAX_HIGH_CYC   = 60,
  parameter int unsigned RESET_CYC      = 1350,
  parameter bit          FORWARD        = 1'b0
) (
  input  logic       Clock,
  input  logic       rst,
  input  logic       WS2812B_DIN,
  output logic       WS2812B_DOUT,
  output logic       pixel_valid,
  output logic [7:0] Green,
  output logic [7:0] Red,
  output logic [7:0] Blue,
  output logic [9:0] pixel_idx,
  output logic       frame_done,
  output logic       error
);

  localparam int unsigned LCNT_W = $clog2(RESET_CYC + 1);
  localparam int unsigned HCNT_W = $clog2(MAX_HIGH_CYC + 2);
  localparam int unsigned BCNT_W = 5;
  localparam int unsigned IDX_W  = 10;
  localparam int unsigned PIX_W  = 24;

  localparam logic [BCNT_W-1:0] PIXEL_BITS = BCNT_W'(PIX_W);
  localparam logic [LCNT_W-1:0] LCNT_END   = LCNT_W'(RESET_CYC);
  localparam logic [LCNT_W-1:0] LCNT_LAST  = LCNT_W'(RESET_CYC - 1);
  localparam logic [HCNT_W-1:0] HCNT_MIN   = HCNT_W'(MIN_HIGH_CYC);
  localparam logic [HCNT_W-1:0] HCNT_ONE   = HCNT_W'(BIT_THRESH_CYC);
  localparam logic [HCNT_W-1:0] HCNT_MAX   = HCNT_W'(MAX_HIGH_CYC);
  localparam logic [HCNT_W-1:0] HCNT_SAT   = HCNT_W'(MAX_HIGH_CYC + 1);

  typedef enum logic [1:0] {
    S_LOW      = 2'd0,
    S_HIGH     = 2'd1,
    S_ERR_WAIT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                din_s_q, din_s_d;
  logic                din_prev_q, din_prev_d;
  logic [LCNT_W-1:0]   lcnt_q, lcnt_d;
  logic [HCNT_W-1:0]   hcnt_q, hcnt_d;
  logic [PIX_W-1:0]    sr_q, sr_d;
  logic [BCNT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic [IDX_W-1:0]    idx_q, idx_d;
  logic                seen_q, seen_d;
  logic                fwd_q, fwd_d;
  logic                pixel_valid_q, pixel_valid_d;
  logic [7:0]          green_q, green_d;
  logic [7:0]          red_q, red_d;
  logic [7:0]          blue_q, blue_d;
  logic [IDX_W-1:0]    pixel_idx_q, pixel_idx_d;
  logic                frame_done_q, frame_done_d;
  logic                error_q, error_d;
  logic                dout_q, dout_d;

  logic rise_c, fall_c, frame_end_c, bit_val_c;

  assign rise_c = din_s_q & ~din_prev_q;
  assign fall_c = ~din_s_q & din_prev_q;

  assign WS2812B_DOUT = dout_q;
  assign pixel_valid  = pixel_valid_q;
  assign Green        = green_q;
  assign Red          = red_q;
  assign Blue         = blue_q;
  assign pixel_idx    = pixel_idx_q;
  assign frame_done   = frame_done_q;
  assign error        = error_q;

  // State register and all datapath flops
  always_ff @(posedge Clock or negedge rst) begin
    if (!rst) begin
      state_q       <= S_LOW;
      sync1_q       <= 1'b0;
      din_s_q       <= 1'b0;
      din_prev_q    <= 1'b0;
      lcnt_q        <= '0;
      hcnt_q        <= '0;
      sr_q          <= '0;
      bit_cnt_q     <= '0;
      idx_q         <= '0;
      seen_q        <= 1'b0;
      fwd_q         <= 1'b0;
      pixel_valid_q <= 1'b0;
      green_q       <= '0;
      red_q         <= '0;
      blue_q        <= '0;
      pixel_idx_q   <= '0;
      frame_done_q  <= 1'b0;
      error_q       <= 1'b0;
      dout_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      sync1_q       <= sync1_d;
      din_s_q       <= din_s_d;
      din_prev_q    <= din_prev_d;
      lcnt_q        <= lcnt_d;
      hcnt_q        <= hcnt_d;
      sr_q          <= sr_d;
      bit_cnt_q     <= bit_cnt_d;
      idx_q         <= idx_d;
      seen_q        <= seen_d;
      fwd_q         <= fwd_d;
      pixel_valid_q <= pixel_valid_d;
      green_q       <= green_d;
      red_q         <= red_d;
      blue_q        <= blue_d;
      pixel_idx_q   <= pixel_idx_d;
      frame_done_q  <= frame_done_d;
      error_q       <= error_d;
      dout_q        <= dout_d;
    end
  end

  // Pulse-width FSM, bit assembly, pixel/frame strobes and forwarding
  always_comb begin
    state_d       = state_q;
    sync1_d       = WS2812B_DIN;
    din_s_d       = sync1_q;
    din_prev_d    = din_s_q;
    lcnt_d        = lcnt_q;
    hcnt_d        = hcnt_q;
    sr_d          = sr_q;
    bit_cnt_d     = bit_cnt_q;
    idx_d         = idx_q;
    seen_d        = seen_q;
    fwd_d         = fwd_q;
    pixel_valid_d = 1'b0;
    green_d       = green_q;
    red_d         = red_q;
    blue_d        = blue_q;
    pixel_idx_d   = pixel_idx_q;
    frame_done_d  = 1'b0;
    error_d       = 1'b0;
    dout_d        = fwd_q & din_s_q;
    frame_end_c   = 1'b0;
    bit_val_c     = (hcnt_q >= HCNT_ONE);

    // A full pixel in the shift register is published one cycle later
    if (bit_cnt_q == PIXEL_BITS) begin
      pixel_valid_d = 1'b1;
      green_d       = sr_q[23:16];
      red_d         = sr_q[15:8];
      blue_d        = sr_q[7:0];
      pixel_idx_d   = idx_q;
      bit_cnt_d     = '0;
      if (FORWARD) begin
        fwd_d = 1'b1;
      end else begin
        idx_d = idx_q + IDX_W'(1);
      end
    end

    case (state_q)
      S_LOW: begin
        if (rise_c) begin
          state_d = S_HIGH;
          hcnt_d  = HCNT_W'(1);
        end else if (lcnt_q != LCNT_END) begin
          lcnt_d = lcnt_q + LCNT_W'(1);
          // Fires only on the step into saturation, so once per gap
          if (lcnt_q == LCNT_LAST) begin
            frame_end_c = 1'b1;
          end
        end
      end
      S_HIGH: begin
        if (fall_c) begin
          state_d = S_LOW;
          lcnt_d  = LCNT_W'(1);
          // Short pulses are glitches; forwarding suspends decoding
          if (!fwd_q && (hcnt_q >= HCNT_MIN)) begin
            sr_d      = {sr_q[PIX_W-2:0], bit_val_c};
            bit_cnt_d = bit_cnt_q + BCNT_W'(1);
            seen_d    = 1'b1;
          end
        end else if (!fwd_q && (hcnt_q == HCNT_MAX)) begin
          state_d   = S_ERR_WAIT;
          hcnt_d    = HCNT_SAT;
          bit_cnt_d = '0;
          error_d   = 1'b1;
        end else if (hcnt_q != HCNT_SAT) begin
          hcnt_d = hcnt_q + HCNT_W'(1);
        end
      end
      S_ERR_WAIT: begin
        if (!din_s_q) begin
          state_d = S_LOW;
          lcnt_d  = LCNT_W'(1);
        end
      end
      default: begin
        state_d = S_LOW;
      end
    endcase

    // Reset gap: close the frame, flag any dangling partial pixel
    if (frame_end_c) begin
      frame_done_d = seen_q;
      error_d      = (bit_cnt_q != '0);
      bit_cnt_d    = '0;
      idx_d        = '0;
      seen_d       = 1'b0;
      fwd_d        = 1'b0;
    end
  end

endmodule

// File: tb/tb_ws2812b_rx.sv
// Bench for ws2812b_rx: one monitor-mode and one chain-mode instance, each
// fed by its own line, checked against an event-level model of the protocol.
module tb_ws2812b_rx;

  localparam int MIN_H = 3;
  localparam int THR_H = 16;
  localparam int MAX_H = 60;
  localparam int RST_L = 1350;

  localparam int K_PIX   = 1;
  localparam int K_FD    = 2;
  localparam int K_ERR   = 3;
  localparam int K_FDERR = 4;
  localparam int K_BAD   = 9;

  typedef struct {
    int          kind;
    logic [23:0] px;
    logic [9:0]  idx;
  } ev_t;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       din_m = 1'b0;
  logic       din_c = 1'b0;
  logic       dout_m, pv_m, fd_m, er_m;
  logic       dout_c, pv_c, fd_c, er_c;
  logic [7:0] g_m, r_m, b_m, g_c, r_c, b_c;
  logic [9:0] idx_m, idx_c;

  int checks = 0;
  int failures = 0;

  ev_t exp0[$];
  ev_t exp1[$];

  // Model state per channel (0 = monitor instance, 1 = chain instance)
  int          m_bits[2];
  logic [23:0] m_sr[2];
  int          m_idx[2];
  bit          m_seen[2];
  bit          m_fwd[2];
  logic [23:0] m_last_px[2];

  // Observed strobe counters
  int pv_cnt[2];
  int fd_cnt[2];
  int err_cnt[2];
  int fderr_cnt[2];

  bit   win = 1'b0;
  logic h1 = 1'b0, h2 = 1'b0, h3 = 1'b0;

  always #5 clk = ~clk;

  ws2812b_rx #(.FORWARD(1'b0)) u_mon (
    .Clock(clk), .rst(rst), .WS2812B_DIN(din_m), .WS2812B_DOUT(dout_m),
    .pixel_valid(pv_m), .Green(g_m), .Red(r_m), .Blue(b_m),
    .pixel_idx(idx_m), .frame_done(fd_m), .error(er_m)
  );

  ws2812b_rx #(.FORWARD(1'b1)) u_chain (
    .Clock(clk), .rst(rst), .WS2812B_DIN(din_c), .WS2812B_DOUT(dout_c),
    .pixel_valid(pv_c), .Green(g_c), .Red(r_c), .Blue(b_c),
    .pixel_idx(idx_c), .frame_done(fd_c), .error(er_c)
  );

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
    end
  endtask

  task automatic push_ev(input int ch, input int kind, input logic [23:0] px, input logic [9:0] idx);
    ev_t e;
    e.kind = kind;
    e.px   = px;
    e.idx  = idx;
    if (ch == 0) exp0.push_back(e);
    else         exp1.push_back(e);
  endtask

  // Protocol model: one high pulse of width h
  task automatic model_pulse(input int ch, input int h);
    if (h < MIN_H || m_fwd[ch]) return;
    if (h > MAX_H) begin
      push_ev(ch, K_ERR, 24'h0, 10'h0);
      m_bits[ch] = 0;
      return;
    end
    m_sr[ch] = {m_sr[ch][22:0], (h >= THR_H) ? 1'b1 : 1'b0};
    m_bits[ch]++;
    m_seen[ch] = 1'b1;
    if (m_bits[ch] == 24) begin
      push_ev(ch, K_PIX, m_sr[ch], 10'(m_idx[ch]));
      m_last_px[ch] = m_sr[ch];
      m_bits[ch] = 0;
      if (ch == 1) m_fwd[ch] = 1'b1;
      else         m_idx[ch] = (m_idx[ch] + 1) % 1024;
    end
  endtask

  // Protocol model: a low stretch of n cycles
  task automatic model_low(input int ch, input int n);
    if (n < RST_L) return;
    if (m_bits[ch] != 0)  push_ev(ch, K_FDERR, 24'h0, 10'h0);
    else if (m_seen[ch])  push_ev(ch, K_FD, 24'h0, 10'h0);
    m_bits[ch] = 0;
    m_idx[ch]  = 0;
    m_seen[ch] = 1'b0;
    m_fwd[ch]  = 1'b0;
  endtask

  task automatic model_reset();
    for (int c = 0; c < 2; c++) begin
      m_bits[c] = 0; m_sr[c] = '0; m_idx[c] = 0; m_seen[c] = 1'b0; m_fwd[c] = 1'b0;
    end
  endtask

  task automatic set_din(input int ch, input logic v);
    if (ch == 0) din_m = v;
    else         din_c = v;
  endtask

  // Entered and left 1 time unit after a rising clock edge
  task automatic pulse(input int ch, input int h, input int l);
    model_pulse(ch, h);
    set_din(ch, 1'b1);
    repeat (h) @(posedge clk);
    #1 set_din(ch, 1'b0);
    repeat (l) @(posedge clk);
    #1;
  endtask

  task automatic low(input int ch, input int n);
    model_low(ch, n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_pixel(input int ch, input logic [23:0] px, input bit randw);
    logic b;
    int h, l;
    for (int i = 23; i >= 0; i--) begin
      b = px[i];
      if (randw) begin
        h = b ? int'($urandom_range(60, 16)) : int'($urandom_range(15, 3));
        l = int'($urandom_range(30, 4));
      end else begin
        h = b ? 23 : 11;
        l = 34 - h;
      end
      pulse(ch, h, l);
      if (randw && $urandom_range(7, 0) == 0)
        pulse(ch, int'($urandom_range(2, 1)), int'($urandom_range(20, 4)));
    end
  endtask

  task automatic check_ev(input int ch, input logic pv, input logic fd, input logic er,
                          input logic [23:0] px, input logic [9:0] idx);
    int  k;
    ev_t e;
    bit  empty;
    if (!(pv || fd || er)) return;
    if (pv && !fd && !er)      k = K_PIX;
    else if (!pv && fd && !er) k = K_FD;
    else if (!pv && !fd && er) k = K_ERR;
    else if (!pv && fd && er)  k = K_FDERR;
    else                       k = K_BAD;
    if (pv) pv_cnt[ch]++;
    if (fd) fd_cnt[ch]++;
    if (er) err_cnt[ch]++;
    if (fd && er) fderr_cnt[ch]++;
    checks++;
    empty = (ch == 0) ? (exp0.size() == 0) : (exp1.size() == 0);
    if (empty) begin
      failures++;
      $display("FAIL ev%0d_unexpected: got kind %0d expected none", ch, k);
      return;
    end
    e = (ch == 0) ? exp0.pop_front() : exp1.pop_front();
    if (e.kind != k) begin
      failures++;
      $display("FAIL ev%0d_kind: got %0d expected %0d", ch, k, e.kind);
    end else if (k == K_PIX && (px !== e.px || idx !== e.idx)) begin
      failures++;
      $display("FAIL ev%0d_pixel: got %06h idx %0d expected %06h idx %0d", ch, px, idx, e.px, e.idx);
    end
  endtask

  // Compare process: strobes against the model queues, DOUT every cycle
  always @(negedge clk) begin
    if (!rst) begin
      win = 1'b0;
    end else begin
      check_ev(0, pv_m, fd_m, er_m, {g_m, r_m, b_m}, idx_m);
      check_ev(1, pv_c, fd_c, er_c, {g_c, r_c, b_c}, idx_c);
    end
    checks++;
    if (dout_m !== 1'b0) begin
      failures++;
      $display("FAIL dout_mon: got %b expected 0", dout_m);
    end
    checks++;
    if (dout_c !== (win ? h3 : 1'b0)) begin
      failures++;
      $display("FAIL dout_chain: got %b expected %b", dout_c, win ? h3 : 1'b0);
    end
    if (rst && pv_c) win = 1'b1;
    if (rst && fd_c) win = 1'b0;
    h3 = h2; h2 = h1; h1 = din_c;
  end

  task automatic chk_zero(input string nm, input int ch);
    if (ch == 0) chk(nm, {dout_m, pv_m, fd_m, er_m, g_m, r_m, b_m}, 32'h0);
    else         chk(nm, {dout_c, pv_c, fd_c, er_c, g_c, r_c, b_c}, 32'h0);
    chk({nm, "_idx"}, 32'((ch == 0) ? idx_m : idx_c), 32'h0);
  endtask

  initial begin
    model_reset();
    for (int c = 0; c < 2; c++) begin
      pv_cnt[c] = 0; fd_cnt[c] = 0; err_cnt[c] = 0; fderr_cnt[c] = 0; m_last_px[c] = '0;
    end
    repeat (3) @(posedge clk);
    #1;
    chk_zero("reset_mon", 0);
    chk_zero("reset_chain", 1);
    rst = 1'b1;

    // Idle line after reset: no strobes at all
    low(0, 2000);
    chk("idle_fd", 32'(fd_cnt[0] + fd_cnt[1]), 32'd0);
    chk("idle_err", 32'(err_cnt[0] + err_cnt[1]), 32'd0);

    // Single pixel
    send_pixel(0, 24'hA53CFF, 1'b0);
    low(0, 1400);
    chk("single_model_px", 32'(m_last_px[0]), 32'hA53CFF);
    chk("single_rgb", {8'h0, g_m, r_m, b_m}, 32'hA53CFF);
    chk("single_idx", 32'(idx_m), 32'd0);
    chk("single_pv_cnt", 32'(pv_cnt[0]), 32'd1);
    chk("single_fd_cnt", 32'(fd_cnt[0]), 32'd1);
    chk("single_err_cnt", 32'(err_cnt[0]), 32'd0);

    // Three pixels, gap, one pixel
    send_pixel(0, 24'h010203, 1'b0);
    send_pixel(0, 24'h405060, 1'b0);
    send_pixel(0, 24'hFFFFFF, 1'b0);
    chk("multi_model_idx", 32'(m_idx[0]), 32'd3);
    low(0, 1400);
    send_pixel(0, 24'h000000, 1'b0);
    low(0, 1400);
    chk("multi_fd_cnt", 32'(fd_cnt[0]), 32'd3);
    chk("multi_pv_cnt", 32'(pv_cnt[0]), 32'd5);
    chk("multi_rgb", {8'h0, g_m, r_m, b_m}, 32'h0);

    // Glitch mid-pixel, over-long high, width boundaries
    for (int i = 23; i >= 0; i--) begin
      pulse(0, (((24'h5A0F81 >> i) & 24'h1) != 0) ? 23 : 11, 10);
      if (i == 13) pulse(0, 2, 12);
    end
    for (int i = 0; i < 6; i++) pulse(0, 23, 11);
    pulse(0, 100, 20);
    send_pixel(0, 24'h123456, 1'b0);
    for (int i = 0; i < 24; i++) begin
      case (i % 4)
        0: pulse(0, 3, 10);
        1: pulse(0, 15, 10);
        2: pulse(0, 16, 10);
        default: pulse(0, 60, 10);
      endcase
    end
    low(0, 20);
    chk("bound_model_px", 32'(m_last_px[0]), 32'h333333);
    chk("bound_rgb", {8'h0, g_m, r_m, b_m}, 32'h333333);
    chk("bound_idx", 32'(idx_m), 32'd2);
    for (int i = 0; i < 5; i++) pulse(0, 11, 23);
    pulse(0, 61, 20);
    send_pixel(0, 24'h0F0F0F, 1'b0);
    low(0, 1400);
    chk("glitch_err_cnt", 32'(err_cnt[0]), 32'd2);
    chk("glitch_rgb", {8'h0, g_m, r_m, b_m}, 32'h0F0F0F);
    chk("glitch_idx", 32'(idx_m), 32'd3);

    // Partial pixel at frame end
    for (int i = 0; i < 12; i++) pulse(0, (i % 3 == 0) ? 23 : 11, 11);
    low(0, 1400);
    chk("partial_fderr", 32'(fderr_cnt[0]), 32'd1);
    chk("partial_pv_cnt", 32'(pv_cnt[0]), 32'd9);

    // Randomised frames
    for (int f = 0; f < 5; f++) begin
      int np;
      np = int'($urandom_range(3, 1));
      for (int p = 0; p < np; p++) send_pixel(0, 24'($urandom), 1'b1);
      low(0, 1400);
    end

    // Async reset mid-pixel
    for (int i = 0; i < 10; i++) pulse(0, 23, 11);
    rst = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    chk_zero("midrst_mon", 0);
    rst = 1'b1;
    low(0, 2000);
    send_pixel(0, 24'hC0FFEE, 1'b0);
    low(0, 1400);
    chk("midrst_rgb", {8'h0, g_m, r_m, b_m}, 32'hC0FFEE);
    chk("midrst_idx", 32'(idx_m), 32'd0);

    // Chain mode: capture first pixel, forward the rest
    send_pixel(1, 24'h112233, 1'b0);
    send_pixel(1, 24'hAABBCC, 1'b0);
    pulse(1, 2, 20);
    pulse(1, 100, 20);
    low(1, 1400);
    chk("chain_pv_cnt", 32'(pv_cnt[1]), 32'd1);
    chk("chain_rgb", {8'h0, g_c, r_c, b_c}, 32'h112233);
    chk("chain_idx", 32'(idx_c), 32'd0);
    chk("chain_fd_cnt", 32'(fd_cnt[1]), 32'd1);
    chk("chain_err_cnt", 32'(err_cnt[1]), 32'd0);
    send_pixel(1, 24'h445566, 1'b1);
    send_pixel(1, 24'h778899, 1'b1);
    low(1, 1400);
    chk("chain2_pv_cnt", 32'(pv_cnt[1]), 32'd2);
    chk("chain2_rgb", {8'h0, g_c, r_c, b_c}, 32'h445566);

    repeat (50) @(posedge clk);
    #1;
    chk("exp0_drained", 32'(exp0.size()), 32'd0);
    chk("exp1_drained", 32'(exp1.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ws2812b_rx.md
Name: ws2812b_rx

Overview:
- Receive-side counterpart of the WS2812B transmitter: decodes the single-wire NRZ LED stream back into 24-bit GRB pixels.
- Used as a loopback checker for the transmitter on the 20K board, and as a chip-accurate LED model (capture first pixel, forward the rest) in system benches.
- Runs from the 27 MHz board clock; all timing thresholds are expressed in clock cycles.

Parameters:
- MIN_HIGH_CYC, 3, high pulses shorter than this are glitches and are ignored
- BIT_THRESH_CYC, 16, high width >= this decodes as 1, otherwise 0 (~0.6 us @27 MHz)
- MAX_HIGH_CYC, 60, high width above this is a protocol error
- RESET_CYC, 1350, low time that ends a frame (50 us @27 MHz)
- FORWARD, 0, 0 = monitor mode (decode every pixel); 1 = chain mode (decode first pixel, forward the rest)

Ports:
- Clock  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- WS2812B_DIN  in  1  serial input, asynchronous to Clock
- WS2812B_DOUT  out  1  forwarded stream (chain mode only)
- pixel_valid  out  1  one-cycle strobe; Red/Green/Blue/pixel_idx valid while it is high
- Green  out  8  decoded green byte
- Red  out  8  decoded red byte
- Blue  out  8  decoded blue byte
- pixel_idx  out  10  index of this pixel within the frame
- frame_done  out  1  one-cycle strobe at frame reset gap
- error  out  1  one-cycle strobe on protocol violation

Behaviour:
- Reset (rst=0, async): all outputs 0; counters, shift register, bit count cleared; forwarding disabled; synchronizer flops cleared to 0.
- Input synchronization: 2-flop synchronizer gives din_s; edges are detected on din_s against its registered copy.
- States:
  - LOW: low-counter lcnt saturates at RESET_CYC.
  - HIGH: high-counter hcnt saturates at MAX_HIGH_CYC+1.
  - ERR_WAIT: wait for din_s to go low.
- Rising edge, from LOW: hcnt=1, go to HIGH.
- Falling edge, from HIGH, go to LOW with lcnt=1, then classify hcnt:
  - hcnt < MIN_HIGH_CYC: glitch; no bit, shift register untouched.
  - otherwise: bit = (hcnt >= BIT_THRESH_CYC); shifted in MSB first; bit_cnt++.
- hcnt exceeds MAX_HIGH_CYC: error strobe; partial pixel discarded (bit_cnt=0); go to ERR_WAIT. On din_s low, go to LOW with lcnt=1.
- Pixel assembly:
  - Wire order is G7..G0, R7..R0, B7..B0.
  - When the 24th bit is shifted in, on the next cycle: pixel_valid=1, Green=sr[23:16], Red=sr[15:8], Blue=sr[7:0], pixel_idx = current index.
  - Then bit_cnt=0; pixel index increments in monitor mode, wrapping at 1023.
  - Colour outputs hold their value between strobes.
- Frame end: lcnt reaching RESET_CYC (exactly once per gap):
  - frame_done=1 if any valid bit was seen since the last frame end.
  - If bit_cnt != 0: error=1 in the same cycle and partial bits are discarded.
  - Pixel index returns to 0; forwarding is disabled.
  - Idle line after reset produces no frame_done.
- Chain mode (FORWARD=1):
  - After the first pixel_valid of a frame, decoding stops: no further pixel_valid and no glitch/width checks.
  - WS2812B_DOUT = registered din_s (3 cycles total latency from WS2812B_DIN) until frame end.
  - Outside forwarding, DOUT = 0.
  - Frame-end detection stays active while forwarding.
  - pixel_idx is always 0.
- Monitor mode: DOUT is held 0.
- Simultaneous events: the pixel_valid strobe and the frame-end check never coincide, because frame end needs RESET_CYC low cycles after the last edge.
- Async reset mid-pixel: clears everything; the next valid frame decodes normally.

Test Plan:
- Reset → all outputs 0. Then 2000 cycles of low line → no frame_done, no error.
- Single pixel G=0xA5 R=0x3C B=0xFF, each bit 34-cycle period (0 = 11 high, 1 = 23 high), then 1400 low → one pixel_valid with Green=A5 Red=3C Blue=FF pixel_idx=0; exactly one frame_done; error never set.
- Monitor mode, 3 pixels (0x010203, 0x405060, 0xFFFFFF), gap, then 1 pixel 0x000000 → pixel_idx 0,1,2, then 0 in the second frame; two frame_done strobes.
- 2-cycle high glitch inserted inside a low period mid-pixel, and a 100-cycle high held in the next pixel → glitch ignored, first pixel decodes exactly. Long high gives an error strobe; that pixel is dropped; the following pixel decodes correctly.
- 12 bits then 1400 low → error and frame_done in the same cycle, no pixel_valid. Async rst pulse mid-pixel → outputs cleared; the next frame decodes correctly.
- FORWARD=1, 48 bits (pixels 0x112233, 0xAABBCC) → a single pixel_valid with G=11 R=22 B=33. WS2812B_DOUT equals WS2812B_DIN delayed 3 cycles for bits 25–48; DOUT returns to 0 after frame_done.
